// File: rtl/feature_dispatcher_pkg.sv
// Shared types for the feature dispatcher: FSM state encoding and feature-code type.
package feature_dispatcher_pkg;

    localparam int FEAT_CODE_W = 3;

    typedef logic [FEAT_CODE_W-1:0] feat_code_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CHECK = 2'b01,
        ST_RUN   = 2'b10,
        ST_DONE  = 2'b11
    } fd_state_e;

endpackage

// File: rtl/feature_dispatcher_if.sv
// Request/grant bundle between the two requesting interfaces, the conflict checker and the dispatcher.
interface feature_dispatcher_if;
    import feature_dispatcher_pkg::*;

    logic       ie1_req;
    feat_code_t ie1_code;
    logic       ie2_req;
    feat_code_t ie2_code;
    logic       cancel;
    feat_code_t chk_code1;
    feat_code_t chk_code2;
    logic       cft_ok;
    logic       grant1;
    logic       grant2;
    logic       reject2;
    logic       busy;
    logic       done;

    modport master (
        output ie1_req, ie1_code, ie2_req, ie2_code, cancel, cft_ok,
        input  chk_code1, chk_code2, grant1, grant2, reject2, busy, done
    );

    modport slave (
        input  ie1_req, ie1_code, ie2_req, ie2_code, cancel, cft_ok,
        output chk_code1, chk_code2, grant1, grant2, reject2, busy, done
    );

endinterface

// File: rtl/feature_run_timer.sv
// Run-length down-counter: loads RUN_CYCLES-1, decrements on request, flags zero from the registered count.
module feature_run_timer #(
    parameter int RUN_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic dec,
    output logic zero
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             zero_q;
    logic             zero_d;

    // Next count: load wins over decrement, and the count never wraps below zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (dec && (cnt_q != CNT_ZERO)) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
        zero_d = (cnt_d == CNT_ZERO);
    end

    // Count and zero-flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= CNT_ZERO;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= zero_d;
        end
    end

    assign zero = zero_q;

endmodule

// File: rtl/feature_dispatcher.sv
// Arbitrates two feature requests through an external conflict checker and keeps the
// granted feature(s) active for RUN_CYCLES cycles; IE01 wins on conflict.
module feature_dispatcher
    import feature_dispatcher_pkg::*;
#(
    parameter int RUN_CYCLES = 8,
    parameter int CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    feature_dispatcher_if.slave  bus
);

    fd_state_e  state_q, state_d;
    feat_code_t code1_q, code1_d;
    feat_code_t code2_q, code2_d;
    logic       p1_q, p1_d;
    logic       p2_q, p2_d;
    logic       grant1_q, grant1_d;
    logic       grant2_q, grant2_d;
    logic       reject2_q, reject2_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       timer_load_s;
    logic       timer_dec_s;
    logic       timer_zero_s;

    feature_run_timer #(
        .RUN_CYCLES (RUN_CYCLES),
        .CNT_W      (CNT_W)
    ) u_run_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (timer_load_s),
        .dec   (timer_dec_s),
        .zero  (timer_zero_s)
    );

    // Next-state and next-output logic; cancel pre-empts every CHECK/RUN transition.
    always_comb begin
        state_d      = state_q;
        code1_d      = code1_q;
        code2_d      = code2_q;
        p1_d         = p1_q;
        p2_d         = p2_q;
        grant1_d     = grant1_q;
        grant2_d     = grant2_q;
        reject2_d    = 1'b0;
        timer_load_s = 1'b0;
        timer_dec_s  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.ie1_req || bus.ie2_req) begin
                    code1_d = bus.ie1_code;
                    code2_d = bus.ie2_code;
                    p1_d    = bus.ie1_req;
                    p2_d    = bus.ie2_req;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (bus.cancel) begin
                    grant1_d = 1'b0;
                    grant2_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    // cft_ok only matters when both sides asked.
                    grant1_d     = p1_q;
                    grant2_d     = p2_q && (!p1_q || bus.cft_ok);
                    reject2_d    = p1_q && p2_q && !bus.cft_ok;
                    timer_load_s = 1'b1;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.cancel) begin
                    grant1_d = 1'b0;
                    grant2_d = 1'b0;
                    state_d  = ST_IDLE;
                end else if (timer_zero_s) begin
                    grant1_d = 1'b0;
                    grant2_d = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    timer_dec_s = 1'b1;
                    state_d     = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                grant1_d = 1'b0;
                grant2_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, latched request context and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            code1_q   <= 3'b000;
            code2_q   <= 3'b000;
            p1_q      <= 1'b0;
            p2_q      <= 1'b0;
            grant1_q  <= 1'b0;
            grant2_q  <= 1'b0;
            reject2_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            code1_q   <= code1_d;
            code2_q   <= code2_d;
            p1_q      <= p1_d;
            p2_q      <= p2_d;
            grant1_q  <= grant1_d;
            grant2_q  <= grant2_d;
            reject2_q <= reject2_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.chk_code1 = code1_q;
    assign bus.chk_code2 = code2_q;
    assign bus.grant1    = grant1_q;
    assign bus.grant2    = grant2_q;
    assign bus.reject2   = reject2_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_feature_dispatcher.sv
// Bench for feature_dispatcher: an 8-cycle and a 1-cycle instance share stimulus and are
// compared every cycle against a dispatch-timeline model, plus directed literal checks.
module tb_feature_dispatcher;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ie1_req, ie2_req, cancel;
    logic [2:0] ie1_code, ie2_code;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    feature_dispatcher_if if8 ();
    feature_dispatcher_if if1 ();

    assign if8.ie1_req  = ie1_req;
    assign if8.ie1_code = ie1_code;
    assign if8.ie2_req  = ie2_req;
    assign if8.ie2_code = ie2_code;
    assign if8.cancel   = cancel;
    assign if8.cft_ok   = (if8.chk_code1 != if8.chk_code2);
    assign if1.ie1_req  = ie1_req;
    assign if1.ie1_code = ie1_code;
    assign if1.ie2_req  = ie2_req;
    assign if1.ie2_code = ie2_code;
    assign if1.cancel   = cancel;
    assign if1.cft_ok   = (if1.chk_code1 != if1.chk_code2);

    feature_dispatcher dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    feature_dispatcher #(.RUN_CYCLES(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    // Timeline model: age 0 idle, 1 check, 2..R+1 grant window, R+2 done pulse.
    int         rl   [2] = '{8, 1};
    int         age  [2];
    logic [2:0] mc1  [2];
    logic [2:0] mc2  [2];
    logic       mp1  [2];
    logic       mp2  [2];
    logic       mg1  [2];
    logic       mg2  [2];
    logic       mrej [2];

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                age[i] <= 0; mc1[i] <= 3'b000; mc2[i] <= 3'b000;
                mp1[i] <= 1'b0; mp2[i] <= 1'b0; mg1[i] <= 1'b0; mg2[i] <= 1'b0; mrej[i] <= 1'b0;
            end else if (age[i] == 0) begin
                if (ie1_req || ie2_req) begin
                    age[i] <= 1; mc1[i] <= ie1_code; mc2[i] <= ie2_code;
                    mp1[i] <= ie1_req; mp2[i] <= ie2_req;
                end
            end else if (cancel && age[i] <= rl[i] + 1) begin
                age[i] <= 0; mg1[i] <= 1'b0; mg2[i] <= 1'b0;
            end else if (age[i] == 1) begin
                mg1[i]  <= mp1[i];
                mg2[i]  <= mp2[i] && !(mp1[i] && mc1[i] == mc2[i]);
                mrej[i] <= mp1[i] && mp2[i] && (mc1[i] == mc2[i]);
                age[i]  <= 2;
            end else if (age[i] == rl[i] + 2) begin
                age[i] <= 0;
            end else begin
                age[i] <= age[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_dut(input int i, input logic b, input logic d, input logic g1,
                           input logic g2, input logic r2, input logic [2:0] c1, input logic [2:0] c2);
        logic in_win;
        in_win = (age[i] >= 2) && (age[i] <= rl[i] + 1);
        check($sformatf("busy%0d", i),    8'(b),  8'(age[i] != 0));
        check($sformatf("done%0d", i),    8'(d),  8'(age[i] == rl[i] + 2));
        check($sformatf("grant1_%0d", i), 8'(g1), 8'(in_win && mg1[i]));
        check($sformatf("grant2_%0d", i), 8'(g2), 8'(in_win && mg2[i]));
        check($sformatf("reject2_%0d", i), 8'(r2), 8'(age[i] == 2 && mrej[i]));
        check($sformatf("code1_%0d", i),  8'(c1), 8'(mc1[i]));
        check($sformatf("code2_%0d", i),  8'(c2), 8'(mc2[i]));
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        cmp_dut(0, if8.busy, if8.done, if8.grant1, if8.grant2, if8.reject2, if8.chk_code1, if8.chk_code2);
        cmp_dut(1, if1.busy, if1.done, if1.grant1, if1.grant2, if1.reject2, if1.chk_code1, if1.chk_code2);
    end

    int g1c, g2c, r2c, dc, d_idx, r2_first, g1c1, dc1, g1_last1, d_idx1;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic measure(input int n);
        g1c = 0; g2c = 0; r2c = 0; dc = 0; d_idx = -1; r2_first = -1;
        g1c1 = 0; dc1 = 0; g1_last1 = -1; d_idx1 = -1;
        for (int k = 0; k < n; k++) begin
            if (if8.grant1) g1c++;
            if (if8.grant2) g2c++;
            if (if8.reject2) begin r2c++; if (r2_first < 0) r2_first = k; end
            if (if8.done) begin dc++; d_idx = k; end
            if (if1.grant1) begin g1c1++; g1_last1 = k; end
            if (if1.done) begin dc1++; d_idx1 = k; end
            @(negedge clk);
        end
    endtask

    task automatic launch(input logic r1, input logic [2:0] c1, input logic r2, input logic [2:0] c2);
        ie1_req = r1; ie1_code = c1; ie2_req = r2; ie2_code = c2;
        @(negedge clk);
        ie1_req = 1'b0; ie2_req = 1'b0;
        check("check_busy", 8'(if8.busy), 8'd1);
        check("check_nogrant", 8'(if8.grant1 | if8.grant2), 8'd0);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ie1_req = 1'b0; ie2_req = 1'b0; cancel = 1'b0;
        ie1_code = 3'b000; ie2_code = 3'b000;
        step(3);
        check("rst_busy", 8'(if8.busy), 8'd0);
        check("rst_grant", 8'({if8.grant1, if8.grant2, if8.reject2, if8.done}), 8'd0);
        check("rst_code1", 8'(if8.chk_code1), 8'd0);
        rst_n = 1'b1;
        step(2);

        // Single IE01 request.
        launch(1'b1, 3'b010, 1'b0, 3'b000);
        check("single_first_grant", 8'(if8.grant1), 8'd1);
        measure(14);
        check("single_g1_cycles", 8'(g1c), 8'd8);
        check("single_g2_cycles", 8'(g2c), 8'd0);
        check("single_done_cnt", 8'(dc), 8'd1);
        check("single_done_idx", 8'(d_idx), 8'd8);
        check("single_idle", 8'(if8.busy), 8'd0);
        check("rc1_grant_cycles", 8'(g1c1), 8'd1);
        check("rc1_done_cnt", 8'(dc1), 8'd1);
        check("rc1_grant_idx", 8'(g1_last1), 8'd0);
        check("rc1_done_idx", 8'(d_idx1), 8'd1);

        // Both requests, no conflict.
        launch(1'b1, 3'b101, 1'b1, 3'b011);
        measure(14);
        check("both_g1_cycles", 8'(g1c), 8'd8);
        check("both_g2_cycles", 8'(g2c), 8'd8);
        check("both_rej", 8'(r2c), 8'd0);

        // Both requests, conflict: IE01 wins.
        launch(1'b1, 3'b110, 1'b1, 3'b110);
        measure(14);
        check("conf_g1_cycles", 8'(g1c), 8'd8);
        check("conf_g2_cycles", 8'(g2c), 8'd0);
        check("conf_rej_cnt", 8'(r2c), 8'd1);
        check("conf_rej_idx", 8'(r2_first), 8'd0);

        // IE02 held during RUN only: no second dispatch.
        launch(1'b1, 3'b001, 1'b0, 3'b000);
        ie2_req = 1'b1; ie2_code = 3'b001;
        step(4);
        ie2_req = 1'b0;
        measure(14);
        check("hold_run_done_cnt", 8'(dc), 8'd1);
        check("hold_run_idle", 8'(if8.busy), 8'd0);

        // IE02 held through DONE: re-accepted after one IDLE cycle.
        launch(1'b1, 3'b100, 1'b0, 3'b000);
        ie2_req = 1'b1; ie2_code = 3'b111;
        step(8);
        check("hold_done_pulse", 8'(if8.done), 8'd1);
        step(1);
        check("hold_idle_gap", 8'(if8.busy), 8'd0);
        step(1);
        check("hold_recheck", 8'(if8.busy), 8'd1);
        check("hold_code2", 8'(if8.chk_code2), 8'd7);
        check("hold_code1", 8'(if8.chk_code1), 8'd4);
        ie2_req = 1'b0;
        measure(14);
        check("hold_g2_cycles", 8'(g2c), 8'd8);
        check("hold_g1_cycles", 8'(g1c), 8'd0);

        // Cancel on the third grant cycle.
        launch(1'b1, 3'b011, 1'b0, 3'b000);
        step(2);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        check("cancel_grant", 8'(if8.grant1), 8'd0);
        check("cancel_busy", 8'(if8.busy), 8'd0);
        measure(12);
        check("cancel_no_done", 8'(dc), 8'd0);

        // Asynchronous reset in the middle of a run.
        launch(1'b1, 3'b001, 1'b1, 3'b010);
        step(2);
        check("prereset_grant", 8'({if8.grant1, if8.grant2}), 8'd3);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outs", 8'({if8.grant1, if8.grant2, if8.reject2, if8.busy, if8.done}), 8'd0);
        check("async_rst_codes", 8'({if8.chk_code1, if8.chk_code2}), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(2);

        // Randomized traffic with occasional cancels and resets.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            ie1_req  = ($urandom_range(0, 3) == 0);
            ie2_req  = ($urandom_range(0, 3) == 0);
            ie1_code = 3'($urandom_range(0, 7));
            ie2_code = ($urandom_range(0, 2) == 0) ? ie1_code : 3'($urandom_range(0, 7));
            cancel   = ($urandom_range(0, 11) == 0);
            #2 rst_n = ($urandom_range(0, 399) != 0);
        end
        @(negedge clk);
        ie1_req = 1'b0; ie2_req = 1'b0; cancel = 1'b0;
        #2 rst_n = 1'b1;
        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/feature_dispatcher.md
FEATURE_DISPATCHER -- requirements
Module: feature_dispatcher

Interface
REQ-001 SHALL have parameter RUN_CYCLES, default 8, meaning cycles a granted feature stays active (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8, meaning run-counter width.
REQ-003 SHALL have port clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ie1_req  input  1  IE01 feature request, level.
REQ-006 SHALL have port ie1_code  input  3  IE01 feature code, MSB first.
REQ-007 SHALL have port ie2_req  input  1  IE02 feature request, level.
REQ-008 SHALL have port ie2_code  input  3  IE02 feature code, MSB first.
REQ-009 SHALL have port cancel  input  1  synchronous abort of the current dispatch.
REQ-010 SHALL have port chk_code1  output  3  latched IE01 code, driven to the conflict checker inputs A,B,C.
REQ-011 SHALL have port chk_code2  output  3  latched IE02 code, driven to the conflict checker inputs D,E,F.
REQ-012 SHALL have port cft_ok  input  1  conflict checker result: 1 = codes differ, 0 = conflict.
REQ-013 SHALL have ports grant1 and grant2  output  1 each  feature active for IE01 and IE02 respectively.
REQ-014 SHALL have port reject2  output  1  one-cycle pulse: IE02 refused due to conflict.
REQ-015 SHALL have port busy  output  1  high in every state other than IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at end of run.

Function
REQ-017 SHALL implement FSM states IDLE, CHECK, RUN, DONE, registered, with outputs decoded from registered state and flags only.
REQ-018 IDLE: if ie1_req or ie2_req is high at an edge, SHALL latch both codes into chk_code1/2 and both reqs into flags p1/p2, then enter CHECK.
REQ-019 CHECK lasts exactly one cycle; cft_ok is sampled at its closing edge only (checker is combinational on chk_code1/2).
REQ-020 CHECK with p1 and p2 both set and cft_ok=1: SHALL set grant1 and grant2.
REQ-021 CHECK with p1 and p2 both set and cft_ok=0: SHALL set grant1 only and pulse reject2 for one cycle (IE01 has priority).
REQ-022 CHECK with a single flag set: SHALL grant only that interface and ignore cft_ok.
REQ-023 On leaving CHECK, SHALL load the counter with RUN_CYCLES-1 and enter RUN.
REQ-024 Grants SHALL be high for exactly RUN_CYCLES cycles, the first cycle being the one after CHECK.
REQ-025 RUN: counter decrements each cycle; at count 0 SHALL enter DONE, clearing grants on that edge.
REQ-026 DONE lasts one cycle with done=1, then returns to IDLE; earliest next CHECK is 1 cycle later.
REQ-027 Latency: request at edge n -> CHECK at n+1 -> grants visible from n+2.
REQ-028 Requests arriving in CHECK, RUN or DONE SHALL be ignored, not queued; a request still held in IDLE is re-accepted.
REQ-029 cancel=1 in CHECK or RUN SHALL force IDLE on the next edge, clear grants, suppress reject2 and done, and take priority over all other transitions; cancel SHALL be ignored in IDLE.
REQ-030 RUN_CYCLES=1 SHALL give one grant cycle followed directly by DONE.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, counter 0, chk_code1/2 = 3'b000, p1/p2 = 0, and grant1, grant2, reject2, busy, done = 0, including in the middle of a run.
REQ-032 The first state change after rst_n rises SHALL be no earlier than the first clk rising edge.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (2-bit encoding) and the 3-bit feature-code typedef.
REQ-034 The conflict checker SHALL remain an external sibling instance wired through chk_code1/2 and cft_ok; the run counter is the only natural sub-module (feature_run_timer, load/decrement/zero flag).

Verification
REQ-035 ie1_req=1 with code 3'b010, ie2_req=0 -> grant1 high for 8 cycles from n+2, grant2=0, done pulse, return to IDLE.
REQ-036 Both requests, codes 3'b101 and 3'b011, cft_ok=1 -> grant1 and grant2 both high for 8 cycles.
REQ-037 Both requests, codes 3'b110 and 3'b110, cft_ok=0 -> grant1 for 8 cycles, one-cycle reject2 at n+2, grant2 never set.
REQ-038 Hold ie2_req during RUN, release it before DONE -> no second dispatch; hold it through DONE -> new CHECK one cycle after DONE.
REQ-039 cancel at 3rd grant cycle -> grants low next cycle, no done pulse; rst_n low mid-RUN -> all outputs 0 immediately.
REQ-040 RUN_CYCLES=1 -> single-cycle grant, done on the following cycle.
